// File: rtl/alu_serial_seq_pkg.sv
// alu_serial_seq_pkg: shared ALU op codes and op-class helper for the serial ALU
package alu_serial_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    // Codes 0..3 all take the adder path; bit 0 selects subtraction.
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/alu_serial_seq_alu1.sv
// alu1: single-bit ALU slice (add/sub via control[0], and/or/nor/xor)
module alu1
    import alu_serial_seq_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       carryin_i,
    input  logic [2:0] control_i,
    output logic       result_o,
    output logic       carryout_o
);

    logic b_eff;

    assign b_eff = b_i ^ control_i[0];

    // Decode the op; anything outside the logic group is a full-adder bit.
    always_comb begin
        result_o   = a_i ^ b_eff ^ carryin_i;
        carryout_o = (a_i & b_eff) | (a_i & carryin_i) | (b_eff & carryin_i);
        case (control_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = a_i ^ b_eff ^ carryin_i;
        endcase
        if (!is_arith(control_i)) carryout_o = 1'b0;
    end

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial WIDTH-bit ALU driving one alu1 slice LSB first
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             last;
    logic             slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] final_res;

    assign accept    = start & ready;
    assign last      = cnt_q == CW'(WIDTH - 1);
    assign final_res = {slice_res, res_q[WIDTH-1:1]};

    alu1 u_slice (
        .a_i        (a_sr_q[0]),
        .b_i        (b_sr_q[0]),
        .carryin_i  (carry_q),
        .control_i  (ctrl_q),
        .result_o   (slice_res),
        .carryout_o (slice_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: a start accepted in DONE chains straight into RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_RUN : S_IDLE;
            S_RUN:   state_d = last ? S_DONE : S_RUN;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        ready = (state_q == S_IDLE) || (state_q == S_DONE);
        busy  = state_q == S_RUN;
        done  = state_q == S_DONE;
    end

    // Datapath next state: load on accept, shift one bit per RUN cycle, publish on the MSB cycle
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        ctrl_d  = ctrl_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (accept) begin
            a_sr_d  = A;
            b_sr_d  = B;
            ctrl_d  = control;
            carry_d = is_arith(control) ? control[0] : 1'b0;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = slice_cout;
            cnt_d   = last ? cnt_q : cnt_q + 1'b1;
            res_d   = final_res;
            if (last) begin
                // carry_q still holds the carry into the MSB on this cycle
                out_d  = final_res;
                cout_d = is_arith(ctrl_q) ? slice_cout : 1'b0;
                ovf_d  = is_arith(ctrl_q) ? (carry_q ^ slice_cout) : 1'b0;
                zero_d = final_res == '0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            ctrl_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            ctrl_q  <= ctrl_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign out      = out_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that computes a WIDTH-bit ALU operation by driving a single existing `alu1` 1-bit slice for WIDTH consecutive cycles, LSB first. It holds the inter-bit carry in a flop and shifts operands and result through internal registers. It reports carryout, overflow and zero at completion. It sits between an issuing controller (start/done handshake) and the area-minimal single-slice datapath.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when ready=1.
- A  input  WIDTH  operand A; latched on accepted start.
- B  input  WIDTH  operand B; latched on accepted start.
- control  input  3  ALU op code: ADD=2, SUB=3, AND=4, OR=5, NOR=6, XOR=7; latched on accepted start.
- ready  output  1  high in IDLE and DONE; start is accepted when ready and start are both high.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- out  output  WIDTH  result; held until the next accepted start.
- carryout  output  1  carry out of the MSB for ADD/SUB; 0 for logic ops.
- overflow  output  1  signed overflow for ADD/SUB; 0 for logic ops.
- zero  output  1  high when out == 0.

## Operation
- States: IDLE → RUN → DONE → IDLE. DONE goes to RUN directly when start is accepted in DONE.
- Accepted start performs these actions:
  - latch A, B and control into shift registers;
  - set the carry flop to control[0] when control[2]=0, else 0;
  - clear the bit counter and the result shift register.
- RUN, each cycle:
  - the slice receives A_sr[0], B_sr[0], the carry flop and the latched control;
  - the slice output shifts into the result register MSB side, so the result ends LSB-aligned;
  - A_sr and B_sr shift right by one;
  - the carry flop takes the slice carryout;
  - the counter increments.
- Leave RUN after the cycle that processes bit WIDTH-1, i.e. when counter == WIDTH-1.
- Before updating on the MSB cycle, capture the carry flop value as c_msb_in.
- On the final edge, register the outputs:
  - out = assembled result;
  - carryout = slice carryout when control[2]=0, else 0;
  - overflow = c_msb_in XOR slice carryout when control[2]=0, else 0;
  - zero = (out == 0).
- Codes 0 and 1 are not rejected. The slice decodes them as ADD and SUB through control[0], and the block treats them as arithmetic.
- A start asserted while busy is ignored and is not queued.
- reset, regardless of state:
  - state returns to IDLE;
  - out, carryout, overflow, zero, busy and done go to 0;
  - ready goes to 1;
  - any operation in flight is discarded and no done is produced.
- Reset values of the outputs: ready=1, busy=0, done=0, out=0, carryout=0, overflow=0, zero=0.
- zero is cleared by reset rather than reflecting out=0; the first valid zero appears with the first done.

## Timing
- Start accepted at edge k. busy is high for cycles k+1 … k+WIDTH. done is high in cycle k+WIDTH+1.
- Latency from the accepting edge to done is WIDTH+1 cycles.
- Throughput is one operation per WIDTH+1 cycles when start is held high continuously. A start accepted in DONE makes busy rise in the next cycle.
- All outputs come from registers. There is no combinational path from any input to ready, busy or done.
- Counter width is $clog2(WIDTH). The counter does not wrap during RUN; it is reloaded only by an accepted start.

## Structure
- The op-code constants (ALU_ADD … ALU_XOR) live in the shared ALU defines header. The slice and this sequencer both include it, and neither redefines the codes.
- One sub-module: a single instance of the existing `alu1` slice, with its carryin driven by the carry flop.
- The state encoding (IDLE/RUN/DONE) stays local to this block.

## Test plan
All scenarios use WIDTH=8.
- ADD, A=0x7F, B=0x01, start at edge k → done only in cycle k+9; out=0x80, carryout=0, overflow=1, zero=0.
- SUB, A=0x05, B=0x05 → out=0x00, carryout=1, overflow=0, zero=1. SUB, A=0x00, B=0x01 → out=0xFF, carryout=0.
- Logic ops, A=0xF0, B=0x3C: AND → 0x30; OR → 0xFC; NOR → 0x03; XOR → 0xCC. For all four, carryout=0 and overflow=0.
- Back-to-back: start held high with ADD 0xFF+0x01 then AND 0xAA&0x0F → first done gives out=0x00, carryout=1, zero=1. Second done arrives exactly 9 cycles later with out=0x0A.
- start pulsed at RUN cycle 3 → ignored; a single done with the original operands' result.
- reset asserted at RUN cycle 4 → next cycle: ready=1, busy=0, out=0, and done never pulses. A fresh start afterwards completes correctly in 9 cycles.
